// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift/rotate unit.
//   - operation encodings (3-bit op field)
//   - FSM state type for the iteration controller
//   - parameter legality check for WIDTH/STEP
package shift_pkg;

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // STEP must be a power of two between 1 and WIDTH/2; WIDTH a power of two >= 8.
  function automatic bit step_legal(input int width, input int step);
    return (width >= 8) && ((width & (width - 1)) == 0) &&
           (step >= 1) && (step <= width / 2) && ((step & (step - 1)) == 0);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One iteration of the shifter: shifts/rotates i_work by i_s bits (0..STEP).
// Built as a mux ladder, one stage per bit of i_s, stage b moving 2**b bits.
// Ports:
//   i_work    [WIDTH-1:0]        operand for this iteration
//   i_op      [2:0]              operation select (illegal codes pass through)
//   i_s       [$clog2(STEP):0]   bits to move this iteration
//   o_shifted [WIDTH-1:0]        combinational result
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic [WIDTH-1:0]       i_work,
  input  logic [2:0]             i_op,
  input  logic [$clog2(STEP):0]  i_s,
  output logic [WIDTH-1:0]       o_shifted
);

  localparam int NST = $clog2(STEP) + 1;

  for (genvar b = 0; b < NST; b++) begin : g_stage
    localparam int SH = 1 << b;
    logic        [WIDTH-1:0] w_in;
    logic signed [WIDTH-1:0] w_in_s;
    logic        [WIDTH-1:0] w_sh;
    logic        [WIDTH-1:0] w_out;

    if (b == 0) begin : g_first
      assign w_in = i_work;
    end else begin : g_chain
      assign w_in = g_stage[b-1].w_out;
    end

    assign w_in_s = w_in;

    always_comb begin
      w_sh = w_in;
      case (i_op)
        OP_SHR:  w_sh = w_in >> SH;
        OP_SHRA: w_sh = w_in_s >>> SH;
        OP_SHL:  w_sh = w_in << SH;
        OP_ROR:  w_sh = (w_in >> SH) | (w_in << (WIDTH - SH));
        OP_ROL:  w_sh = (w_in << SH) | (w_in >> (WIDTH - SH));
        default: w_sh = w_in;
      endcase
    end

    // stage boundary: take the 2**b move only when bit b of the count is set
    assign w_out = i_s[b] ? w_sh : w_in;
  end

  assign o_shifted = g_stage[NST-1].w_out;

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shift/rotate unit (SHR, SHRA, SHL, ROR, ROL), at most STEP bits
// per clock. Launched with start while idle; done pulses one cycle when the
// held result register is updated.
// Ports:
//   clock              system clock, rising edge
//   clear              asynchronous active-high reset
//   start              request, accepted when busy=0
//   op     [2:0]       operation select; 101..111 pass the operand through
//   value  [WIDTH-1:0] operand, sampled on accept
//   amount [SHW-1:0]   shift count, sampled on accept
//   busy               operation in progress
//   done               one-cycle completion pulse
//   result [WIDTH-1:0] registered result, held until the next done
module iterative_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] value,
  input  logic [SHW-1:0]   amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int SW = $clog2(STEP) + 1;

  if (!step_legal(WIDTH, STEP)) begin : g_bad_params
    $error("iterative_shifter: WIDTH/STEP combination is not supported");
  end

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_shifted;
  logic [SHW-1:0]   r_rem;
  logic [SHW-1:0]   w_rem_next;
  logic [2:0]       r_op;
  logic [SW-1:0]    w_s;
  logic             r_done;
  logic             w_accept;
  logic             w_last;
  logic             w_op_legal;

  assign w_accept   = start && (r_state == S_IDLE);
  assign w_op_legal = (op <= OP_ROL);

  // Move min(rem, STEP) bits this cycle.
  always_comb begin
    if (r_rem >= SHW'(STEP)) w_s = SW'(STEP);
    else                     w_s = SW'(r_rem);
  end

  assign w_rem_next = r_rem - SHW'(w_s);
  // A zero count still spends one RUN cycle with s=0, so done keys off rem-s.
  assign w_last     = (w_rem_next == '0);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .i_work    (r_work),
    .i_op      (r_op),
    .i_s       (w_s),
    .o_shifted (w_shifted)
  );

  // FSM state register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last)   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy   = (r_state == S_RUN);
    done   = r_done;
    result = r_result;
  end

  // Operand, counter and result registers. Illegal ops load a zero count so
  // they complete with the n=0 latency and return the operand unchanged.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_work   <= '0;
      r_rem    <= '0;
      r_op     <= OP_SHR;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_work <= value;
        r_rem  <= w_op_legal ? amount : '0;
        r_op   <= op;
      end else if (r_state == S_RUN) begin
        r_work <= w_shifted;
        r_rem  <= w_rem_next;
        if (w_last) begin
          r_result <= w_shifted;
          r_done   <= 1'b1;
        end
      end
    end
  end

endmodule
